// File: rtl/alien_fire_scheduler.sv
// Alien return-fire scheduler: after each cooldown picks the next live column
// round-robin and the lowest free bullet slot, pulses launch, then awaits flight.
module alien_fire_scheduler #(
  parameter int NUM_COLS       = 8,
  parameter int NUM_SLOTS      = 2,
  parameter int TICK_CYCLES    = 36000,
  parameter int COOLDOWN_TICKS = 40,
  parameter int ACK_TIMEOUT    = 4
) (
  input  logic                        clk_36MHz,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_COLS-1:0]         col_valid,
  input  logic [NUM_SLOTS-1:0]        slot_busy,
  output logic [NUM_SLOTS-1:0]        launch,
  output logic [$clog2(NUM_COLS)-1:0] launch_col,
  output logic                        launch_fail,
  output logic [7:0]                  fire_count
);

  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int COOL_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_COOLDOWN = 2'd0,
    ST_SELECT   = 2'd1,
    ST_LAUNCH   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [COOL_W-1:0]   cool_q, cool_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [COL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SLOT_W-1:0]   slot_sel_q, slot_sel_d;
  logic [NUM_SLOTS-1:0] launch_q, launch_d;
  logic [COL_W-1:0]    launch_col_q, launch_col_d;
  logic                launch_fail_q, launch_fail_d;
  logic [7:0]          fire_count_q, fire_count_d;

  logic                tick;
  logic                can_fire;
  logic                acked;
  logic                timed_out;
  logic [COL_W-1:0]    col_pick;
  logic [SLOT_W-1:0]   slot_pick;

  // First requesting column at or after ptr, wrapping modulo NUM_COLS.
  function automatic logic [COL_W-1:0] rr_pick(input logic [NUM_COLS-1:0] req,
                                               input logic [COL_W-1:0]    ptr);
    logic [COL_W-1:0] pick;
    logic [COL_W-1:0] idx_v;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_COLS) idx = idx - NUM_COLS;
      idx_v = COL_W'(idx);
      if (!found && req[idx_v]) begin
        pick  = idx_v;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
    logic [SLOT_W-1:0] pick;
    logic [SLOT_W-1:0] i_v;
    pick = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      i_v = SLOT_W'(i);
      if (!busy[i_v]) pick = i_v;
    end
    return pick;
  endfunction

  function automatic logic [COL_W-1:0] col_after(input logic [COL_W-1:0] c);
    return (int'(c) == NUM_COLS - 1) ? '0 : c + COL_W'(1);
  endfunction

  assign tick      = enable && (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
  assign can_fire  = (|col_valid) && !(&slot_busy);
  assign acked     = slot_busy[slot_sel_q];
  assign timed_out = (ack_cnt_q >= ACK_W'(ACK_TIMEOUT - 1));
  assign col_pick  = rr_pick(col_valid, rr_ptr_q);
  assign slot_pick = lowest_free(slot_busy);

  always_ff @(posedge clk_36MHz) begin
    if (reset) state_q <= ST_COOLDOWN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_COOLDOWN;
    end else begin
      case (state_q)
        ST_COOLDOWN: if (cool_q == '0 || (tick && cool_q == COOL_W'(1))) state_d = ST_SELECT;
        ST_SELECT:   if (can_fire) state_d = ST_LAUNCH;
        ST_LAUNCH:   state_d = ST_WAIT_ACK;
        ST_WAIT_ACK: if (acked || timed_out) state_d = ST_COOLDOWN;
        default:     state_d = ST_COOLDOWN;
      endcase
    end
  end

  // The ack counter is zero in LAUNCH and counts that cycle too, so the
  // fail pulse lands ACK_TIMEOUT cycles after the launch pulse.
  always_comb begin
    tick_cnt_d    = tick ? '0 : tick_cnt_q + TICK_W'(1);
    cool_d        = cool_q;
    ack_cnt_d     = ack_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    slot_sel_d    = slot_sel_q;
    launch_d      = '0;
    launch_col_d  = launch_col_q;
    launch_fail_d = 1'b0;
    fire_count_d  = fire_count_q;
    if (!enable) begin
      tick_cnt_d = '0;
      cool_d     = COOL_W'(COOLDOWN_TICKS);
    end else begin
      case (state_q)
        ST_COOLDOWN: begin
          if (tick && cool_q != '0) cool_d = cool_q - COOL_W'(1);
        end
        ST_SELECT: begin
          if (can_fire) begin
            launch_col_d = col_pick;
            slot_sel_d   = slot_pick;
            rr_ptr_d     = col_after(col_pick);
            launch_d     = NUM_SLOTS'(1) << slot_pick;
            ack_cnt_d    = '0;
          end
        end
        ST_LAUNCH: begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
        ST_WAIT_ACK: begin
          if (acked) begin
            fire_count_d = fire_count_q + 8'd1;
            cool_d       = COOL_W'(COOLDOWN_TICKS);
          end else if (timed_out) begin
            launch_fail_d = 1'b1;
            cool_d        = COOL_W'(COOLDOWN_TICKS);
          end else begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      cool_q        <= COOL_W'(COOLDOWN_TICKS);
      rr_ptr_q      <= '0;
      launch_q      <= '0;
      launch_col_q  <= '0;
      launch_fail_q <= 1'b0;
      fire_count_q  <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      cool_q        <= cool_d;
      rr_ptr_q      <= rr_ptr_d;
      launch_q      <= launch_d;
      launch_col_q  <= launch_col_d;
      launch_fail_q <= launch_fail_d;
      fire_count_q  <= fire_count_d;
    end
    ack_cnt_q  <= ack_cnt_d;
    slot_sel_q <= slot_sel_d;
  end

  assign launch      = launch_q;
  assign launch_col  = launch_col_q;
  assign launch_fail = launch_fail_q;
  assign fire_count  = fire_count_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Bench for alien_fire_scheduler: timeline model of cooldown/select/ack windows
// plus directed scenarios with hand-computed column order and timing.
module tb_alien_fire_scheduler;

  localparam int NC   = 8;
  localparam int NS   = 2;
  localparam int TICK = 4;
  localparam int COOL = 2;
  localparam int ACK  = 4;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [NC-1:0] col_valid;
  logic [NS-1:0] slot_busy, force_busy, bm_busy, bm_pend;
  logic          bm_on;
  logic [NS-1:0] launch;
  logic [2:0]    launch_col;
  logic          launch_fail;
  logic [7:0]    fire_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;
  int bm_cnt [NS];

  int lq[$];
  int lt[$];
  int ls[$];
  int ft[$];

  assign slot_busy = (bm_on ? bm_busy : '0) | force_busy;

  alien_fire_scheduler #(
    .NUM_COLS(NC), .NUM_SLOTS(NS), .TICK_CYCLES(TICK),
    .COOLDOWN_TICKS(COOL), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk_36MHz(clk), .reset(reset), .enable(enable), .col_valid(col_valid),
    .slot_busy(slot_busy), .launch(launch), .launch_col(launch_col),
    .launch_fail(launch_fail), .fire_count(fire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Bullet model: busy for three cycles starting the cycle after a launch.
  initial begin
    bm_busy = '0;
    bm_pend = '0;
    for (int s = 0; s < NS; s++) bm_cnt[s] = 0;
  end
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < NS; s++) begin
      if (bm_pend[s]) bm_cnt[s] = 3;
      else if (bm_cnt[s] > 0) bm_cnt[s] = bm_cnt[s] - 1;
      bm_busy[s] = (bm_cnt[s] > 0);
    end
    bm_pend = launch;
  end

  // Timeline model: absolute cycle numbers for tick phase, select start and launch.
  int tick0, sel_start, m_l, m_rr, m_slot;
  logic [NS-1:0] e_launch;
  logic [2:0]    e_col;
  logic          e_fail;
  logic [7:0]    e_fire;

  function automatic int first_select(input int s0);
    int k, t1;
    if (COOL == 0) return s0 + 1;
    k  = (s0 - tick0) % TICK;
    t1 = s0 + (TICK - 1 - k);
    return t1 + (COOL - 1) * TICK + 1;
  endfunction

  function automatic bit bit_of(input int vec, input int i);
    return ((vec >> i) & 1) != 0;
  endfunction

  always @(posedge clk) begin
    int p, c, s;
    p = cyc;
    cyc = cyc + 1;
    e_launch = '0;
    e_fail   = 1'b0;
    if (reset || !enable) begin
      if (reset) begin
        e_col  = '0;
        e_fire = '0;
        m_rr   = 0;
      end
      tick0     = cyc;
      sel_start = first_select(cyc);
      m_l       = -1;
    end else if (m_l >= 0) begin
      if (p > m_l) begin
        if (bit_of(int'(slot_busy), m_slot)) begin
          e_fire    = e_fire + 8'd1;
          m_l       = -1;
          sel_start = first_select(cyc);
        end else if (p >= m_l + ACK - 1) begin
          e_fail    = 1'b1;
          m_l       = -1;
          sel_start = first_select(cyc);
        end
      end
    end else if (p >= sel_start && col_valid != '0 && slot_busy != '1) begin
      c = m_rr;
      while (!bit_of(int'(col_valid), c)) c = (c + 1) % NC;
      s = 0;
      while (bit_of(int'(slot_busy), s)) s = s + 1;
      e_col    = 3'(c);
      m_rr     = (c + 1) % NC;
      m_slot   = s;
      e_launch = NS'(1 << s);
      m_l      = cyc;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("launch", int'(launch), int'(e_launch));
      chk("launch_col", int'(launch_col), int'(e_col));
      chk("launch_fail", int'(launch_fail), int'(e_fail));
      chk("fire_count", int'(fire_count), int'(e_fire));
      chk("launch_onehot", ($countones(launch) <= 1) ? 1 : 0, 1);
      if (launch != '0) begin
        lq.push_back(int'(launch_col));
        lt.push_back(cyc);
        ls.push_back(int'(launch));
      end
      if (launch_fail) ft.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_q(input bit use_ft, input int n, input string name);
    int k;
    k = 0;
    while (((use_ft ? ft.size() : lq.size()) < n) && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) timeout_fail(name);
  endtask

  task automatic wait_launch(output int t, input string name);
    bit got;
    got = 0;
    t = -1;
    for (int k = 0; k < 200 && !got; k++) begin
      step(1);
      if (launch != '0) begin
        got = 1;
        t = cyc;
      end
    end
    if (!got) timeout_fail(name);
  endtask

  initial begin
    int r, d, x, t, t2, nft;
    reset      = 1'b1;
    enable     = 1'b1;
    col_valid  = 8'hFF;
    force_busy = 2'b10;
    bm_on      = 1'b0;
    step(3);
    chk("rst_launch", int'(launch), 0);
    chk("rst_launch_col", int'(launch_col), 0);
    chk("rst_launch_fail", int'(launch_fail), 0);
    chk("rst_fire_count", int'(fire_count), 0);

    // Round-robin order with the bullet model acknowledging.
    reset      = 1'b0;
    col_valid  = 8'b1000_0101;
    force_busy = 2'b00;
    bm_on      = 1'b1;
    r = cyc;
    step(6);
    chk("no_early_launch", lq.size(), 0);
    wait_q(0, 4, "rr_launches");
    chk("rr_col0", lq[0], 0);
    chk("rr_col1", lq[1], 2);
    chk("rr_col2", lq[2], 7);
    chk("rr_col3", lq[3], 0);
    chk("first_launch_latency", lt[0] - r, 9);
    chk("launch_spacing", lt[1] - lt[0], 8);
    chk("rr_slot", ls[0], 1);
    step(2);
    chk("rr_fire_count", int'(fire_count), 4);

    // All slots busy, then slot 0 frees.
    force_busy = 2'b11;
    lq.delete(); lt.delete(); ls.delete();
    step(30);
    chk("busy_no_launch", lq.size(), 0);
    force_busy = 2'b10;
    d = cyc;
    wait_q(0, 1, "drop_launch");
    chk("drop_to_launch", lt[0] - d, 1);
    chk("drop_slot", ls[0], 1);
    chk("drop_col", lq[0], 2);

    // Slot 0 held busy: always slot 1.
    force_busy = 2'b01;
    lq.delete(); lt.delete(); ls.delete();
    wait_q(0, 3, "slot1_launches");
    for (int i = 0; i < 3; i++) chk("slot1_used", ls[i], 2);
    chk("slot1_col0", lq[0], 7);
    chk("slot1_col1", lq[1], 0);
    chk("slot1_col2", lq[2], 2);
    step(2);
    chk("slot1_fire_count", int'(fire_count), 8);

    // No acknowledgement at all.
    force_busy = 2'b00;
    bm_on      = 1'b0;
    reset      = 1'b1;
    lq.delete(); lt.delete(); ls.delete(); ft.delete();
    step(1);
    reset = 1'b0;
    r = cyc;
    wait_q(1, 3, "fail_pulses");
    chk("nack_col0", lq[0], 0);
    chk("nack_col1", lq[1], 2);
    chk("nack_col2", lq[2], 7);
    for (int i = 0; i < 3; i++) chk("fail_delay", ft[i] - lt[i], 4);
    chk("nack_first_latency", lt[0] - r, 9);
    chk("nack_fire_count", int'(fire_count), 0);

    // Abort in WAIT_ACK by dropping enable.
    wait_launch(t, "abort_en_launch");
    chk("abort_en_pre_col", int'(launch_col), 0);
    nft = ft.size();
    step(1);
    enable = 1'b0;
    x = cyc;
    step(1);
    enable = 1'b1;
    chk("abort_en_launch_low", int'(launch), 0);
    chk("abort_en_col_hold", int'(launch_col), 0);
    wait_launch(t2, "abort_en_relaunch");
    chk("abort_en_full_cooldown", t2 - x, 10);
    chk("abort_en_no_fail", ft.size(), nft);
    chk("abort_en_next_col", int'(launch_col), 2);

    // Abort in WAIT_ACK by reset.
    step(1);
    reset = 1'b1;
    x = cyc;
    step(1);
    reset = 1'b0;
    nft = ft.size();
    chk("abort_rst_launch_low", int'(launch), 0);
    chk("abort_rst_col", int'(launch_col), 0);
    wait_launch(t, "abort_rst_relaunch");
    chk("abort_rst_full_cooldown", t - x, 10);
    chk("abort_rst_no_fail", ft.size(), nft);
    chk("abort_rst_fire", int'(fire_count), 0);
    chk("abort_rst_next_col", int'(launch_col), 0);
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
